spi_read_fetcher: RTL and testbench

//  SPI mode-0 master that fetches one byte from an external serial RAM with READ (0x03) + address.

---
 rtl/spi_read_fetcher.sv | 219 +++++++++++++++++++++
 tb/tb_spi_read_fetcher.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_read_fetcher.sv
// spi_read_fetcher: SPI mode-0 master that reads one byte from a serial RAM (CMD + address + 8 data bits).
// Define SPI_BURST_EN to keep cs_n low between reads so a sequential address streams with only 8 SCK pulses.
module spi_read_fetcher #(
    parameter int unsigned CLK_DIV   = 1,
    parameter int unsigned ADDR_BITS = 8,
    parameter logic [7:0]  CMD       = 8'h03
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [ADDR_BITS-1:0] addr,
    output logic                 ready,
    output logic [7:0]           rdata,
    output logic                 valid,
    output logic                 cs_n,
    output logic                 sck,
    output logic                 mosi,
    input  logic                 miso
);

    if (CLK_DIV == 0) begin : g_bad_clk_div
        $error("spi_read_fetcher: CLK_DIV must be at least 1");
    end
    if (ADDR_BITS == 0 || (ADDR_BITS % 8) != 0) begin : g_bad_addr_bits
        $error("spi_read_fetcher: ADDR_BITS must be a non-zero multiple of 8");
    end

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = $clog2(2 * CLK_DIV);
    localparam int unsigned BIT_W = $clog2(ADDR_BITS);
    localparam int unsigned SH_W  = 8 + ADDR_BITS;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BYTE_LAST = BIT_W'(7);
    localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(ADDR_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_DONE,
        S_CSHI
`ifdef SPI_BURST_EN
        , S_HOLD
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q,   div_d;
    logic [GAP_W-1:0]  gap_q,   gap_d;
    logic [BIT_W-1:0]  bit_q,   bit_d;
    logic              sck_q,   sck_d;
    logic              cs_n_q,  cs_n_d;
    logic [SH_W-1:0]   sh_out_q, sh_out_d;
    logic [7:0]        sh_in_q, sh_in_d;
    logic [7:0]        rdata_q, rdata_d;
`ifdef SPI_BURST_EN
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 pend_q, pend_d;
`endif

    logic             tick;
    logic [BIT_W-1:0] bit_last;

    assign tick     = (div_q == DIV_LAST);
    assign bit_last = (state_q == S_ADDR) ? ADDR_LAST : BYTE_LAST;

    // The outgoing shift register doubles as the MOSI flop: it drains to zero by the DATA phase.
    assign mosi  = sh_out_q[SH_W-1];
    assign sck   = sck_q;
    assign cs_n  = cs_n_q;
    assign rdata = rdata_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        div_d    = div_q;
        gap_d    = gap_q;
        bit_d    = bit_q;
        sck_d    = sck_q;
        cs_n_d   = cs_n_q;
        sh_out_d = sh_out_q;
        sh_in_d  = sh_in_q;
        rdata_d  = rdata_q;
`ifdef SPI_BURST_EN
        addr_d   = addr_q;
        pend_d   = pend_q;
`endif
        ready    = 1'b0;
        valid    = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    state_d  = S_CMD;
                    cs_n_d   = 1'b0;
                    sh_out_d = {CMD, addr};
`ifdef SPI_BURST_EN
                    addr_d   = addr;
`endif
                end
            end

            S_CMD, S_ADDR, S_DATA: begin
                div_d = div_q + 1'b1;
                if (tick) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        sh_in_d = {sh_in_q[6:0], miso};
                    end else begin
                        // Falling SCK ends a bit; the next MOSI bit appears while SCK is low.
                        sh_out_d = sh_out_q << 1;
                        bit_d    = bit_q + 1'b1;
                        if (bit_q == bit_last) begin
                            bit_d = '0;
                            case (state_q)
                                S_CMD:   state_d = S_ADDR;
                                S_ADDR:  state_d = S_DATA;
                                default: begin
                                    state_d = S_DONE;
                                    rdata_d = sh_in_q;
`ifndef SPI_BURST_EN
                                    cs_n_d  = 1'b1;
`endif
                                end
                            endcase
                        end
                    end
                end
            end

            S_DONE: begin
                valid = 1'b1;
`ifdef SPI_BURST_EN
                state_d = S_HOLD;
`else
                state_d = S_CSHI;
                gap_d   = '0;
`endif
            end

            S_CSHI: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
`ifdef SPI_BURST_EN
                    if (pend_q) begin
                        pend_d   = 1'b0;
                        state_d  = S_CMD;
                        cs_n_d   = 1'b0;
                        sh_out_d = {CMD, addr_q};
                    end
`endif
                end
            end

`ifdef SPI_BURST_EN
            S_HOLD: begin
                ready = 1'b1;
                if (req) begin
                    addr_d = addr;
                    if (addr == addr_q + 1'b1) begin
                        state_d = S_DATA;
                    end else begin
                        // Non-sequential: close the burst, then run a full read from the latched address.
                        state_d = S_CSHI;
                        cs_n_d  = 1'b1;
                        gap_d   = '0;
                        pend_d  = 1'b1;
                    end
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            gap_q    <= '0;
            bit_q    <= '0;
            sck_q    <= 1'b0;
            cs_n_q   <= 1'b1;
            sh_out_q <= '0;
            sh_in_q  <= '0;
            rdata_q  <= '0;
`ifdef SPI_BURST_EN
            addr_q   <= '0;
            pend_q   <= 1'b0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            div_q    <= div_d;
            gap_q    <= gap_d;
            bit_q    <= bit_d;
            sck_q    <= sck_d;
            cs_n_q   <= cs_n_d;
            sh_out_q <= sh_out_d;
            sh_in_q  <= sh_in_d;
            rdata_q  <= rdata_d;
`ifdef SPI_BURST_EN
            addr_q   <= addr_d;
            pend_q   <= pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_read_fetcher.sv
// tb_spi_read_fetcher: directed bench for spi_read_fetcher with a behavioural 256-byte READ-only SPI RAM.
// Instance 0 uses default parameters, instance 1 uses CLK_DIV=3; both share the RAM contents.
module tb_spi_read_fetcher;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         lat;
    } vec_t;

    typedef struct {
        logic [7:0]  d;
        int          lat;
        logic [23:0] bits;
        int          pulses;
        logic        cs_gap;
        logic        cs_v;
        logic        sck_v;
        logic        v_after;
        int          rise_n;
        int          fall_n;
    } res_t;

`ifdef SPI_BURST_EN
    localparam logic CS_AT_VALID = 1'b0;
`else
    localparam logic CS_AT_VALID = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_v = '0;
    logic [7:0] addr_v [2];
    wire  [1:0] ready_w, valid_w, cs_w, sck_w, mosi_w, miso_w;
    wire  [7:0] rdata_w [2];
    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_read_fetcher dut (
        .clk(clk), .rst(rst), .req(req_v[0]), .addr(addr_v[0]),
        .ready(ready_w[0]), .rdata(rdata_w[0]), .valid(valid_w[0]),
        .cs_n(cs_w[0]), .sck(sck_w[0]), .mosi(mosi_w[0]), .miso(miso_w[0])
    );

    spi_read_fetcher #(.CLK_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .req(req_v[1]), .addr(addr_v[1]),
        .ready(ready_w[1]), .rdata(rdata_w[1]), .valid(valid_w[1]),
        .cs_n(cs_w[1]), .sck(sck_w[1]), .mosi(mosi_w[1]), .miso(miso_w[1])
    );

    // Serial RAM: shifts in 16 bits (command + address), then streams bytes on SCK falls.
    for (genvar g = 0; g < 2; g++) begin : g_ram
        logic [15:0] rx_q   = '0;
        int          rx_cnt = 0;
        int          dcnt   = 0;
        logic        miso_r = 1'b0;
        logic        cs_p   = 1'b1;
        logic        sck_p  = 1'b0;
        logic [7:0]  byte_a;

        always @(cs_w[g] or sck_w[g]) begin
            if (cs_w[g] !== cs_p) begin
                rx_cnt = 0;
                dcnt   = 0;
            end else if (!cs_w[g] && sck_w[g] && !sck_p && rx_cnt < 16) begin
                rx_q   = {rx_q[14:0], mosi_w[g]};
                rx_cnt = rx_cnt + 1;
            end else if (!cs_w[g] && !sck_w[g] && sck_p && rx_cnt >= 16) begin
                byte_a = rx_q[7:0] + 8'(dcnt / 8);
                miso_r = mem[byte_a][7 - (dcnt % 8)];
                dcnt   = dcnt + 1;
            end
            cs_p  = cs_w[g];
            sck_p = sck_w[g];
        end

        assign miso_w[g] = miso_r;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, event not seen within budget", name);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input int idx, output logic ok);
        int n;
        n = 0;
        while (!ready_w[idx] && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = ready_w[idx];
        if (!ok) timeout("wait_ready");
    endtask

    // Issues one single-cycle request and records what the pins did until the valid pulse.
    task automatic read_op(input int idx, input logic [7:0] a, output res_t r);
        logic ok;
        logic prev_sck;
        r = '{d: 8'h00, lat: -1, bits: '0, pulses: 0, cs_gap: 1'b0, cs_v: 1'b0,
              sck_v: 1'b0, v_after: 1'b0, rise_n: -1, fall_n: -1};
        wait_ready(idx, ok);
        if (!ok) return;
        req_v[idx]  = 1'b1;
        addr_v[idx] = a;
        prev_sck = sck_w[idx];
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 1) req_v[idx] = 1'b0;
            if (valid_w[idx]) begin
                r.lat   = n;
                r.d     = rdata_w[idx];
                r.cs_v  = cs_w[idx];
                r.sck_v = sck_w[idx];
                break;
            end
            if (cs_w[idx]) r.cs_gap = 1'b1;
            if (sck_w[idx] && !prev_sck) begin
                r.pulses++;
                r.bits = {r.bits[22:0], mosi_w[idx]};
                if (r.rise_n < 0) r.rise_n = n;
            end
            if (!sck_w[idx] && prev_sck && r.fall_n < 0) r.fall_n = n;
            prev_sck = sck_w[idx];
        end
        if (r.lat < 0) begin
            timeout("read_valid");
            return;
        end
        @(negedge clk);
        r.v_after = valid_w[idx];
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [7];
        res_t r;
        logic ok;
        int   vcount, v1, a2, v2;

        addr_v[0] = '0;
        addr_v[1] = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5C;

        vecs[0] = '{a: 8'h05, d: 8'h66, lat: 49};
        vecs[1] = '{a: 8'h01, d: 8'hA5, lat: 49};
        vecs[2] = '{a: 8'hFF, d: 8'h5A, lat: 49};
        vecs[3] = '{a: 8'h80, d: 8'h01, lat: 49};
        vecs[4] = '{a: 8'h7F, d: 8'hFE, lat: 49};
        vecs[5] = '{a: 8'h3C, d: 8'h00, lat: 49};
        vecs[6] = '{a: 8'hC3, d: 8'hFF, lat: 49};
        for (int i = 0; i < 7; i++) mem[vecs[i].a] = vecs[i].d;

        // Reset values on both instances.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_cs_n[%0d]", i),  cs_w[i],    1);
            check($sformatf("reset_sck[%0d]", i),   sck_w[i],   0);
            check($sformatf("reset_mosi[%0d]", i),  mosi_w[i],  0);
            check($sformatf("reset_ready[%0d]", i), ready_w[i], 1);
            check($sformatf("reset_valid[%0d]", i), valid_w[i], 0);
            check($sformatf("reset_rdata[%0d]", i), rdata_w[i], 0);
        end

        // Table of full reads on the default instance.
        for (int i = 0; i < 7; i++) begin
`ifdef SPI_BURST_EN
            pulse_rst();
`endif
            read_op(0, vecs[i].a, r);
            check($sformatf("rdata[%0d]", i),      r.d,       vecs[i].d);
            check($sformatf("latency[%0d]", i),    r.lat,     vecs[i].lat);
            check($sformatf("mosi_bits[%0d]", i),  r.bits,    {8'h03, vecs[i].a, 8'h00});
            check($sformatf("sck_pulses[%0d]", i), r.pulses,  24);
            check($sformatf("cs_gap[%0d]", i),     r.cs_gap,  0);
            check($sformatf("cs_at_valid[%0d]", i), r.cs_v,   CS_AT_VALID);
            check($sformatf("sck_at_valid[%0d]", i), r.sck_v, 0);
            check($sformatf("valid_pulse[%0d]", i), r.v_after, 0);
            check($sformatf("first_rise[%0d]", i), r.rise_n,  2);
            check($sformatf("first_fall[%0d]", i), r.fall_n,  3);
        end

        // CLK_DIV=3 instance: 3-cycle half periods, valid at T+145.
        mem[8'h00] = 8'h10;
        read_op(1, 8'h00, r);
        check("div3_rdata",      r.d,      8'h10);
        check("div3_latency",    r.lat,    145);
        check("div3_first_rise", r.rise_n, 4);
        check("div3_first_fall", r.fall_n, 7);
        check("div3_pulses",     r.pulses, 24);
        check("div3_mosi_bits",  r.bits,   24'h030000);

        // Reset during the address phase aborts cleanly.
        pulse_rst();
        mem[8'h0A] = 8'hB4;
        wait_ready(0, ok);
        req_v[0]  = 1'b1;
        addr_v[0] = 8'h0A;
        @(negedge clk);
        req_v[0] = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_cs_n",  cs_w[0],    1);
        check("abort_sck",   sck_w[0],   0);
        check("abort_ready", ready_w[0], 1);
        check("abort_valid", valid_w[0], 0);
        check("abort_rdata", rdata_w[0], 0);
        vcount = 0;
        repeat (80) begin
            @(negedge clk);
            if (valid_w[0]) vcount++;
        end
        check("abort_no_valid", vcount, 0);
        read_op(0, 8'h0A, r);
        check("after_abort_rdata",   r.d,   8'hB4);
        check("after_abort_latency", r.lat, 49);

`ifndef SPI_BURST_EN
        // req held high: one valid per accept, re-accept only after the cs_n high gap.
        mem[8'h21] = 8'h3E;
        wait_ready(0, ok);
        req_v[0]  = 1'b1;
        addr_v[0] = 8'h21;
        vcount = 0;
        v1 = -1;
        a2 = -1;
        v2 = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (valid_w[0]) begin
                vcount++;
                if (v1 < 0) v1 = n;
                else v2 = n;
            end
            if (v1 >= 0 && a2 < 0 && ready_w[0]) a2 = n;
            if (v2 >= 0) break;
        end
        req_v[0] = 1'b0;
        if (v2 < 0) timeout("held_req_second_valid");
        check("held_first_valid", v1,      49);
        check("held_reaccept",    a2 - v1, 3);
        check("held_second",      v2 - a2, 49);
        check("held_valid_count", vcount,  2);
        check("held_rdata",       rdata_w[0], 8'h3E);
`else
        // Burst: FF -> 00 continues without cs_n; 00 -> 07 closes and reopens.
        pulse_rst();
        mem[8'hFF] = 8'hC7;
        mem[8'h00] = 8'h3B;
        mem[8'h07] = 8'h9E;
        read_op(0, 8'hFF, r);
        check("burst_first_rdata",   r.d,    8'hC7);
        check("burst_first_latency", r.lat,  49);
        check("burst_first_cs",      r.cs_v, 0);
        check("burst_hold_ready",    ready_w[0], 1);
        read_op(0, 8'h00, r);
        check("burst_seq_rdata",   r.d,      8'h3B);
        check("burst_seq_latency", r.lat,    17);
        check("burst_seq_pulses",  r.pulses, 8);
        check("burst_seq_cs_gap",  r.cs_gap, 0);
        check("burst_seq_cs",      r.cs_v,   0);
        read_op(0, 8'h07, r);
        check("burst_jump_rdata",   r.d,      8'h9E);
        check("burst_jump_latency", r.lat,    51);
        check("burst_jump_pulses",  r.pulses, 24);
        check("burst_jump_cs_gap",  r.cs_gap, 1);
        check("burst_jump_bits",    r.bits,   24'h030700);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
